// File: rtl/ir_pkg.sv
// ir_pkg: shared IR link state encoding and timing constants for both ends of the link
package ir_pkg;
  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} ir_state_t;
  localparam int BIT_CYCLES = 80000;
  localparam int MARK_ONE = 60000;
  localparam int MARK_ZERO = 20000;
  localparam int GAP_CYCLES = 100000;
  localparam int CARRIER_HALF = 1316;
  localparam int SAMPLE_CYCLES = 40000;
  localparam int MIN_CYCLES = 78000;
  localparam int MAX_CYCLES = 90000;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: carrier phase divider, restarted high on each rising EN and held low while EN is low
module ir_carrier_gen #(
  parameter int HALF = ir_pkg::CARRIER_HALF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  output logic PHASE
);
  localparam int DW = $clog2(HALF + 1);
  logic [DW-1:0] div;
  logic en_d;
  logic wrap;
  assign wrap = div == DW'(HALF - 1);
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div <= '0;
      en_d <= 1'b0;
      PHASE <= 1'b0;
    end else begin
      en_d <= EN;
      div <= (!EN || !en_d || wrap) ? '0 : div + 1'b1;
      PHASE <= !EN ? 1'b0 : !en_d ? 1'b1 : wrap ? !PHASE : PHASE;
    end
  end
endmodule

// File: rtl/ir_send.sv
// ir_send: serialises one byte per request into 8 pulse-width IR bit cells followed by a resync gap
module ir_send #(
  parameter int BIT_CYCLES = ir_pkg::BIT_CYCLES,
  parameter int MARK_ONE = ir_pkg::MARK_ONE,
  parameter int MARK_ZERO = ir_pkg::MARK_ZERO,
  parameter int GAP_CYCLES = ir_pkg::GAP_CYCLES,
  parameter int CARRIER_HALF = ir_pkg::CARRIER_HALF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DATA,
  input  logic       SEND,
  output logic       READY,
  output logic       DONE,
  output logic       TX_ENV,
  output logic       TX_OUT
);
  localparam int CW = $clog2(ir_pkg::max_int(BIT_CYCLES, GAP_CYCLES));
  ir_pkg::ir_state_t state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shift, shift_n;
  logic ready_n, done_n, env_n;
  logic mark_end, cell_end, gap_end;
  assign mark_end = cyc == (shift[0] ? CW'(MARK_ONE - 1) : CW'(MARK_ZERO - 1));
  assign cell_end = cyc == CW'(BIT_CYCLES - 1);
  assign gap_end = cyc == CW'(GAP_CYCLES - 1);
  a_legal: assert property (@(posedge CLK)
    MARK_ZERO < BIT_CYCLES / 2 && BIT_CYCLES / 2 < MARK_ONE && MARK_ONE < BIT_CYCLES);
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ir_pkg::IDLE;
      cyc <= '0;
      bit_idx <= '0;
      shift <= '0;
      READY <= 1'b1;
      DONE <= 1'b0;
      TX_ENV <= 1'b1;
    end else begin
      state <= state_n;
      cyc <= cyc_n;
      bit_idx <= bit_n;
      shift <= shift_n;
      READY <= ready_n;
      DONE <= done_n;
      TX_ENV <= env_n;
    end
  end
  // cyc runs across the whole cell so mark and space share one counter
  always_comb begin
    state_n = state;
    cyc_n = (state == ir_pkg::IDLE) ? '0 : cyc + 1'b1;
    bit_n = bit_idx;
    shift_n = shift;
    ready_n = READY;
    done_n = 1'b0;
    env_n = TX_ENV;
    case (state)
      ir_pkg::IDLE:
        if (!READY) ready_n = 1'b1;
        else if (SEND) begin
          state_n = ir_pkg::MARK;
          shift_n = DATA;
          bit_n = '0;
          ready_n = 1'b0;
          env_n = 1'b0;
        end
      ir_pkg::MARK:
        if (mark_end) begin
          state_n = ir_pkg::SPACE;
          env_n = 1'b1;
        end
      ir_pkg::SPACE:
        if (cell_end) begin
          cyc_n = '0;
          if (bit_idx == 3'd7) state_n = ir_pkg::GAP;
          else begin
            state_n = ir_pkg::MARK;
            bit_n = bit_idx + 3'd1;
            shift_n = shift >> 1;
            env_n = 1'b0;
          end
        end
      ir_pkg::GAP:
        if (gap_end) begin
          state_n = ir_pkg::IDLE;
          cyc_n = '0;
          done_n = 1'b1;
        end
      default: state_n = ir_pkg::IDLE;
    endcase
  end
  // enabling on the next state keeps the carrier phase aligned with the registered envelope
  ir_carrier_gen #(.HALF(CARRIER_HALF)) u_carrier (
    .CLK(CLK),
    .RESET(RESET),
    .EN(state_n == ir_pkg::MARK),
    .PHASE(TX_OUT)
  );
endmodule

// File: tb/tb_ir_send.sv
// tb_ir_send: randomized bench checking ir_send against a cycle-offset model and an envelope decoder
module tb_ir_send;
  localparam int B = 40, M1 = 30, M0 = 10, G = 50, H = 3;
  localparam int FRAME = 8 * B + G + 1;
  logic CLK = 1'b0, RESET = 1'b0, SEND = 1'b0;
  logic [7:0] DATA = 8'h00;
  logic READY, DONE, TX_ENV, TX_OUT;
  int n_checks = 0, n_err = 0;
  logic chk_en = 1'b0;
  logic m_active = 1'b0;
  int m_k = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int done_cnt = 0;
  ir_send #(.BIT_CYCLES(B), .MARK_ONE(M1), .MARK_ZERO(M0), .GAP_CYCLES(G), .CARRIER_HALF(H)) dut (
    .CLK(CLK), .RESET(RESET), .DATA(DATA), .SEND(SEND),
    .READY(READY), .DONE(DONE), .TX_ENV(TX_ENV), .TX_OUT(TX_OUT)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  // expected {READY, DONE, TX_ENV, TX_OUT} k cycles after the accepting edge
  function automatic logic [3:0] exp_vec(input logic act, input int k, input logic [7:0] b);
    int pos;
    logic mk;
    if (!act) return 4'b1010;
    if (k > 8 * B) return {1'b0, k == FRAME, 1'b1, 1'b0};
    pos = (k - 1) % B;
    mk = pos < (b[(k - 1) / B] ? M1 : M0);
    return {1'b0, 1'b0, !mk, mk && ((pos / H) % 2 == 0)};
  endfunction
  initial forever begin
    @(posedge CLK or posedge RESET);
    if (RESET) m_active = 1'b0;
    else if (m_active) begin
      if (m_k == FRAME) begin
        m_active = 1'b0;
        exp_q.push_back(m_byte);
      end else m_k++;
    end else if (SEND) begin
      m_active = 1'b1;
      m_k = 1;
      m_byte = DATA;
    end
  end
  // envelope decoder: bit value is the envelope level half a cell after each falling edge
  initial begin
    logic prev_env = 1'b1;
    int cnt = 1 << 20;
    int nb = 0;
    logic [7:0] sh = 8'h00;
    forever begin
      @(negedge CLK);
      if (chk_en) check("outs", {28'b0, READY, DONE, TX_ENV, TX_OUT}, {28'b0, exp_vec(m_active, m_k, m_byte)});
      if (RESET) begin
        nb = 0;
        cnt = 1 << 20;
      end else begin
        cnt = (prev_env && !TX_ENV) ? 0 : cnt + 1;
        if (cnt == B / 2) begin
          sh = {~TX_ENV, sh[7:1]};
          nb++;
          if (nb == 8) begin
            rx_q.push_back(sh);
            nb = 0;
          end
        end
        if (DONE) done_cnt++;
      end
      prev_env = TX_ENV;
    end
  end
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (!READY && t < 2000) begin
      @(negedge CLK);
      t++;
    end
    check("ready_timeout", 32'(t >= 2000), 32'd0);
    SEND = 1'b1;
    DATA = b;
    @(negedge CLK);
    SEND = 1'b0;
    DATA = 8'($urandom);
  endtask
  initial begin
    logic [7:0] dir[5] = '{8'h01, 8'hA5, 8'h00, 8'hFF, 8'h81};
    #1 RESET = 1'b1;
    @(negedge CLK);
    check("rst_outs", {28'b0, READY, DONE, TX_ENV, TX_OUT}, 32'b1010);
    chk_en = 1'b1;
    @(negedge CLK) RESET = 1'b0;
    foreach (dir[i]) begin
      send_byte(dir[i]);
      repeat (9) @(negedge CLK);
      SEND = 1'b1;
      DATA = 8'h3C;
      @(negedge CLK);
      SEND = 1'b0;
    end
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      SEND = $urandom_range(0, 29) == 0;
      DATA = 8'($urandom);
    end
    SEND = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      DATA = 8'($urandom);
      @(negedge CLK);
    end
    SEND = 1'b0;
    for (int r = 0; r < 3; r++) begin
      send_byte(8'($urandom));
      repeat (4 * B + $urandom_range(1, B - 2)) @(negedge CLK);
      #2 RESET = 1'b1;
      #1 check("rst_async", {30'b0, TX_ENV, TX_OUT}, 32'b10);
      @(negedge CLK);
      @(negedge CLK) RESET = 1'b0;
      send_byte(8'h5A);
    end
    repeat (FRAME + 20) @(negedge CLK);
    check("rx_count", rx_q.size(), exp_q.size());
    check("done_count", done_cnt, exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) check("rx_byte", rx_q[i], exp_q[i]);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
